// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: header field layout,
// command limits, transmitter state encoding and small byte helpers.
package router_pkg;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 5;

  localparam logic [1:0] DEST_INVALID = 2'd3;
  localparam logic [3:0] MAX_LEN      = 4'd15;

  // Width of the buffered-byte count exposed on fifo_count.
  localparam int COUNT_W = 5;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_HDR     = 3'd1,
    TX_PAYLOAD = 3'd2,
    TX_PARITY  = 3'd3,
    TX_GAP     = 3'd4
  } tx_state_t;

  // Header byte: top two bits zero, length, destination.
  function automatic logic [7:0] make_header(input logic [1:0] dest, input logic [3:0] len);
    logic [7:0] hdr;
    hdr = 8'h00;
    hdr[HDR_DEST_MSB:HDR_DEST_LSB] = dest;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    return hdr;
  endfunction

  // Running parity: XOR of every byte folded in so far.
  function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // A command the router could never route is dropped instead of sent.
  function automatic logic cmd_is_invalid(input logic [1:0] dest, input logic [3:0] len);
    return (dest == DEST_INVALID) || (len == 4'd0);
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host/router-facing signal bundle of router_pkt_tx.
// master: the host/test source side; slave: the transmitter itself.
// ROUTER_TX_ERR_INJECT_EN adds the inject_err request line.
interface router_pkt_tx_if;
  import router_pkg::*;

  logic               data_valid;
  logic [7:0]         data_in;
  logic               data_ready;
  logic               cmd_valid;
  logic [1:0]         cmd_dest;
  logic [3:0]         cmd_len;
  logic               cmd_ready;
  logic               busy_i;
  logic               pkt_valid;
  logic [7:0]         pkt_data;
  logic               tx_done;
  logic               cmd_err;
  logic [COUNT_W-1:0] fifo_count;
`ifdef ROUTER_TX_ERR_INJECT_EN
  logic               inject_err;
`endif

  modport master (
`ifdef ROUTER_TX_ERR_INJECT_EN
    output inject_err,
`endif
    output data_valid, data_in, cmd_valid, cmd_dest, cmd_len, busy_i,
    input  data_ready, cmd_ready, pkt_valid, pkt_data, tx_done, cmd_err, fifo_count
  );

  modport slave (
`ifdef ROUTER_TX_ERR_INJECT_EN
    input  inject_err,
`endif
    input  data_valid, data_in, cmd_valid, cmd_dest, cmd_len, busy_i,
    output data_ready, cmd_ready, pkt_valid, pkt_data, tx_done, cmd_err, fifo_count
  );

endinterface

// File: rtl/router_tx_fifo.sv
// Synchronous payload FIFO, 8 bits wide, DEPTH entries. The head entry is
// visible combinationally; reset flushes pointers and count (contents kept).
// A push is only taken while there is room, a pop only while data is held.
module router_tx_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         head,
  output logic [COUNT_W-1:0] count,
  output logic               can_push
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]         mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [COUNT_W-1:0] count_r;
  logic               push_s;
  logic               pop_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  assign can_push = (count_r < COUNT_W'(DEPTH));
  assign push_s   = push & can_push;
  assign pop_s    = pop & (count_r != {COUNT_W{1'b0}});
  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;

  // Storage write; no reset needed since the count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {COUNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_W'(1);
        2'b01:   count_r <= count_r - COUNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 3-channel router input port. Host payload bytes
// are buffered, then a command emits header, payload and parity back to back
// with pkt_valid high, followed by a quiet gap so the router can check parity.
// Optional feature: define ROUTER_TX_ERR_INJECT_EN to add inject_err, which
// flips bit 0 of the parity byte of the packet it was sampled with.
//
// state_r names what is on pkt_valid/pkt_data during the current cycle; the
// next-state logic computes the following cycle's outputs, which are loaded
// into output registers together with the state.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic           clk,
  input  logic           resetn,
  router_pkt_tx_if.slave bus
);

  // The gap counter holds the low cycles still owed before IDLE; the IDLE
  // cycle itself is the last low cycle, so GAP lasts GAP_CYCLES-1 cycles.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = $bits(MAX_LEN);

  tx_state_t          state_r, state_s;
  logic [RW-1:0]      rem_r, rem_s;
  logic [7:0]         parity_r, parity_s;
  logic [GW-1:0]      gap_r, gap_s;
  logic               inject_r, inject_s;
  logic               pkt_valid_r, pkt_valid_s;
  logic [7:0]         pkt_data_r, pkt_data_s;
  logic               tx_done_r, tx_done_s;
  logic               cmd_err_r, cmd_err_s;
  logic               cmd_ready_s;
  logic               cmd_bad_s;
  logic               pop_s;
  logic [7:0]         hdr_s;
  logic [7:0]         head_s;
  logic [COUNT_W-1:0] count_s;
  logic               can_push_s;

  router_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (bus.data_valid),
    .din      (bus.data_in),
    .pop      (pop_s),
    .head     (head_s),
    .count    (count_s),
    .can_push (can_push_s)
  );

  assign cmd_bad_s      = cmd_is_invalid(bus.cmd_dest, bus.cmd_len);
  assign hdr_s          = make_header(bus.cmd_dest, bus.cmd_len);
  assign bus.data_ready = can_push_s;
  assign bus.fifo_count = count_s;
  assign bus.cmd_ready  = cmd_ready_s;
  assign bus.pkt_valid  = pkt_valid_r;
  assign bus.pkt_data   = pkt_data_r;
  assign bus.tx_done    = tx_done_r;
  assign bus.cmd_err    = cmd_err_r;

  // Next state and next-cycle outputs. A payload byte is popped on the edge
  // that moves it onto pkt_data, so the FIFO head is always the next byte.
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    parity_s    = parity_r;
    gap_s       = gap_r;
    inject_s    = inject_r;
    pkt_valid_s = 1'b0;
    pkt_data_s  = 8'h00;
    tx_done_s   = 1'b0;
    cmd_err_s   = 1'b0;
    cmd_ready_s = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      TX_IDLE: begin
        // Requiring the whole payload up front is what keeps the packet bubble-free.
        cmd_ready_s = !bus.busy_i && (gap_r == {GW{1'b0}}) &&
                      (cmd_bad_s || (count_s >= COUNT_W'(bus.cmd_len)));
        if (bus.cmd_valid && cmd_ready_s) begin
          if (cmd_bad_s) begin
            cmd_err_s = 1'b1;
          end else begin
            state_s     = TX_HDR;
            pkt_valid_s = 1'b1;
            pkt_data_s  = hdr_s;
            parity_s    = hdr_s;
            rem_s       = bus.cmd_len;
`ifdef ROUTER_TX_ERR_INJECT_EN
            inject_s    = bus.inject_err;
`else
            inject_s    = 1'b0;
`endif
          end
        end else begin
          state_s = TX_IDLE;
        end
      end
      TX_HDR: begin
        state_s     = TX_PAYLOAD;
        pkt_valid_s = 1'b1;
        pkt_data_s  = head_s;
        pop_s       = 1'b1;
        parity_s    = parity_fold(parity_r, head_s);
        rem_s       = rem_r - RW'(1);
      end
      TX_PAYLOAD: begin
        pkt_valid_s = 1'b1;
        if (rem_r != {RW{1'b0}}) begin
          pkt_data_s = head_s;
          pop_s      = 1'b1;
          parity_s   = parity_fold(parity_r, head_s);
          rem_s      = rem_r - RW'(1);
        end else begin
          state_s    = TX_PARITY;
          pkt_data_s = parity_fold(parity_r, {7'b0000000, inject_r});
          tx_done_s  = 1'b1;
        end
      end
      TX_PARITY: begin
        gap_s = GW'(GAP_CYCLES - 1);
        if (gap_s != {GW{1'b0}}) begin
          state_s = TX_GAP;
        end else begin
          state_s = TX_IDLE;
        end
      end
      TX_GAP: begin
        if (gap_r != GW'(1)) begin
          gap_s   = gap_r - GW'(1);
          state_s = TX_GAP;
        end else begin
          gap_s   = {GW{1'b0}};
          state_s = TX_IDLE;
        end
      end
      default: begin
        state_s = TX_IDLE;
        gap_s   = {GW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= TX_IDLE;
      rem_r       <= {RW{1'b0}};
      parity_r    <= 8'h00;
      gap_r       <= {GW{1'b0}};
      inject_r    <= 1'b0;
      pkt_valid_r <= 1'b0;
      pkt_data_r  <= 8'h00;
      tx_done_r   <= 1'b0;
      cmd_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      rem_r       <= rem_s;
      parity_r    <= parity_s;
      gap_r       <= gap_s;
      inject_r    <= inject_s;
      pkt_valid_r <= pkt_valid_s;
      pkt_data_r  <= pkt_data_s;
      tx_done_r   <= tx_done_s;
      cmd_err_r   <= cmd_err_s;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx. A queue holds the bytes the host has
// pushed; each packet's expected stream (header, payload, XOR parity, quiet
// gap) is rebuilt from that queue. Inputs change 1 time unit after the rising
// edge and outputs are read there too.
module tb_router_pkt_tx;
  import router_pkg::*;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic clk;
  logic resetn;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_data  [0:31];
  logic       exp_valid [0:31];
  logic       exp_done  [0:31];
  logic [7:0] obs_data  [0:31];
  logic       obs_valid [0:31];
  logic       obs_done  [0:31];
  int         exp_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    bus.cmd_valid  = 1'b0;
    bus.cmd_dest   = 2'd0;
    bus.cmd_len    = 4'd0;
    bus.busy_i     = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
    bus.inject_err = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    model_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    #1;
    while (bus.data_ready !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    if (bus.data_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: data_ready stuck at %b, wanted 1", bus.data_ready);
    end else begin
      tick();
      model_q.push_back(b);
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] dest, input logic [3:0] len, output bit ok);
    int waited;
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_dest  = dest;
    bus.cmd_len   = len;
    #1;
    while (bus.cmd_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    ok = (bus.cmd_ready === 1'b1);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_timeout: cmd_ready stuck at %b, wanted 1", bus.cmd_ready);
    end else begin
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

  // Expected stream from the packet rules: header, len queued bytes, XOR of
  // all of them (bit 0 flipped on injection), then GAP quiet cycles.
  task automatic build_expected(input logic [1:0] dest, input logic [3:0] len, input logic inj);
    logic [7:0] par;
    logic [7:0] b;
    for (int i = 0; i < 32; i++) begin
      exp_data[i]  = 8'h00;
      exp_valid[i] = 1'b0;
      exp_done[i]  = 1'b0;
    end
    exp_n        = int'(len) + 2 + GAP;
    exp_data[0]  = {2'b00, len, dest};
    exp_valid[0] = 1'b1;
    par          = exp_data[0];
    for (int i = 1; i <= int'(len); i++) begin
      b            = model_q.pop_front();
      exp_data[i]  = b;
      exp_valid[i] = 1'b1;
      par          = par ^ b;
    end
    exp_data[int'(len) + 1]  = par ^ {7'b0000000, inj};
    exp_valid[int'(len) + 1] = 1'b1;
    exp_done[int'(len) + 1]  = 1'b1;
  endtask

  // Record n cycles of router-side outputs, optionally toggling busy_i.
  task automatic capture(input int n, input bit wiggle_busy);
    for (int i = 0; i < n; i++) begin
      obs_valid[i] = bus.pkt_valid;
      obs_data[i]  = bus.pkt_data;
      obs_done[i]  = bus.tx_done;
      if (wiggle_busy) begin
        bus.busy_i = 1'($urandom_range(1, 0));
      end
      tick();
    end
    bus.busy_i = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    if ({bus.pkt_valid, bus.pkt_data, bus.tx_done, bus.cmd_err} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b d=%h done=%b err=%b, want all 0",
               bus.pkt_valid, bus.pkt_data, bus.tx_done, bus.cmd_err);
    end
    n_cmp++;
    if (bus.fifo_count !== 5'd0 || bus.data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_fifo: got count=%0d ready=%b, want 0 / 1", bus.fifo_count, bus.data_ready);
    end
    resetn = 1'b1;
    model_q.delete();
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    apply_reset();
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    n_cmp++;
    if (bus.fifo_count !== 5'd3) begin
      n_bad++;
      $display("FAIL basic_level: got %0d, want 3", bus.fifo_count);
    end
    send_cmd(2'd1, 4'd3, ok);
    build_expected(2'd1, 4'd3, 1'b0);
    capture(exp_n, 1'b0);
    n_cmp++;
    if (obs_data[0] !== 8'h0D || obs_data[4] !== 8'hAD) begin
      n_bad++;
      $display("FAIL basic_hdr_par: got %h/%h, want 0D/AD", obs_data[0], obs_data[4]);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++;
      if (obs_valid[i] !== exp_valid[i] || obs_data[i] !== exp_data[i] || obs_done[i] !== exp_done[i]) begin
        n_bad++;
        $display("FAIL basic_stream[%0d]: got v=%b d=%h done=%b, want v=%b d=%h done=%b",
                 i, obs_valid[i], obs_data[i], obs_done[i], exp_valid[i], exp_data[i], exp_done[i]);
      end
    end
    n_cmp++;
    if (bus.fifo_count !== 5'd0) begin
      n_bad++;
      $display("FAIL basic_drain: got %0d, want 0", bus.fifo_count);
    end
  endtask

  task automatic test_level_wait();
    apply_reset();
    push_byte(8'h3C);
    push_byte(8'hC3);
    bus.cmd_valid = 1'b1;
    bus.cmd_dest  = 2'd0;
    bus.cmd_len   = 4'd4;
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL level_two: got cmd_ready=%b, want 0", bus.cmd_ready);
    end
    push_byte(8'h5A);
    n_cmp++;
    if (bus.cmd_ready !== 1'b0 || bus.pkt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL level_three: got ready=%b v=%b, want 0/0", bus.cmd_ready, bus.pkt_valid);
    end
    push_byte(8'hA5);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL level_four: got cmd_ready=%b, want 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    build_expected(2'd0, 4'd4, 1'b0);
    capture(exp_n, 1'b0);
    n_cmp++;
    if (obs_data[0] !== 8'h10) begin
      n_bad++;
      $display("FAIL level_hdr: got %h, want 10", obs_data[0]);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++;
      if (obs_valid[i] !== exp_valid[i] || obs_data[i] !== exp_data[i] || obs_done[i] !== exp_done[i]) begin
        n_bad++;
        $display("FAIL level_stream[%0d]: got v=%b d=%h done=%b, want v=%b d=%h done=%b",
                 i, obs_valid[i], obs_data[i], obs_done[i], exp_valid[i], exp_data[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int low;
    apply_reset();
    push_byte(8'h55);
    push_byte(8'h66);
    bus.cmd_valid = 1'b1;
    bus.cmd_dest  = 2'd0;
    bus.cmd_len   = 4'd1;
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got %b, want 1", bus.cmd_ready);
    end
    tick();
    accepts = 1;
    for (int i = 0; i < 16; i++) begin
      obs_valid[i] = bus.pkt_valid;
      obs_data[i]  = bus.pkt_data;
      obs_done[i]  = bus.tx_done;
      if (bus.cmd_valid && bus.cmd_ready) begin
        accepts++;
        tick();
        bus.cmd_valid = 1'b0;
      end else begin
        tick();
      end
    end
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (accepts !== 2) begin
      n_bad++;
      $display("FAIL b2b_accepts: got %0d, want 2", accepts);
    end
    low = 0;
    for (int i = 3; i < 16 && obs_valid[i] === 1'b0; i++) low++;
    n_cmp++;
    if (low !== GAP) begin
      n_bad++;
      $display("FAIL b2b_gap: got %0d low cycles, want %0d", low, GAP);
    end
    for (int p = 0; p < 2; p++) begin
      build_expected(2'd0, 4'd1, 1'b0);
      for (int i = 0; i < exp_n; i++) begin
        n_cmp++;
        if (obs_valid[p*exp_n+i] !== exp_valid[i] || obs_data[p*exp_n+i] !== exp_data[i] ||
            obs_done[p*exp_n+i] !== exp_done[i]) begin
          n_bad++;
          $display("FAIL b2b_stream[%0d]: got v=%b d=%h done=%b, want v=%b d=%h done=%b",
                   p*exp_n+i, obs_valid[p*exp_n+i], obs_data[p*exp_n+i], obs_done[p*exp_n+i],
                   exp_valid[i], exp_data[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_errors_busy();
    logic [1:0] bad_dest [0:1];
    logic [3:0] bad_len  [0:1];
    bad_dest[0] = 2'd3; bad_len[0] = 4'd2;
    bad_dest[1] = 2'd2; bad_len[1] = 4'd0;
    apply_reset();
    push_byte(8'h11);
    push_byte(8'h22);
    for (int k = 0; k < 2; k++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_dest  = bad_dest[k];
      bus.cmd_len   = bad_len[k];
      #1;
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL err_ready[%0d]: got %b, want 1", k, bus.cmd_ready);
      end
      tick();
      bus.cmd_valid = 1'b0;
      n_cmp++;
      if (bus.cmd_err !== 1'b1 || bus.pkt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL err_pulse[%0d]: got err=%b v=%b, want 1/0", k, bus.cmd_err, bus.pkt_valid);
      end
      tick();
      n_cmp++;
      if (bus.cmd_err !== 1'b0 || bus.pkt_valid !== 1'b0 || bus.fifo_count !== 5'd2) begin
        n_bad++;
        $display("FAIL err_after[%0d]: got err=%b v=%b count=%0d, want 0/0/2",
                 k, bus.cmd_err, bus.pkt_valid, bus.fifo_count);
      end
    end
    bus.busy_i    = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_dest  = 2'd2;
    bus.cmd_len   = 4'd2;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (bus.cmd_ready !== 1'b0 || bus.pkt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_hold[%0d]: got ready=%b v=%b, want 0/0", c, bus.cmd_ready, bus.pkt_valid);
      end
      tick();
    end
    bus.busy_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_release: got cmd_ready=%b, want 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    build_expected(2'd2, 4'd2, 1'b0);
    capture(exp_n, 1'b0);
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++;
      if (obs_valid[i] !== exp_valid[i] || obs_data[i] !== exp_data[i] || obs_done[i] !== exp_done[i]) begin
        n_bad++;
        $display("FAIL busy_stream[%0d]: got v=%b d=%h done=%b, want v=%b d=%h done=%b",
                 i, obs_valid[i], obs_data[i], obs_done[i], exp_valid[i], exp_data[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int dones;
    apply_reset();
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    send_cmd(2'd1, 4'd5, ok);
    tick();
    tick();
    // Second payload byte is on the wire now.
    resetn = 1'b0;
    tick();
    n_cmp++;
    if (bus.pkt_valid !== 1'b0 || bus.fifo_count !== 5'd0 || bus.tx_done !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_clear: got v=%b count=%0d done=%b, want 0/0/0",
               bus.pkt_valid, bus.fifo_count, bus.tx_done);
    end
    resetn = 1'b1;
    model_q.delete();
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.tx_done === 1'b1 || bus.pkt_valid === 1'b1) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL midrst_quiet: got %0d active cycles, want 0", dones);
    end
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    send_cmd(2'd0, 4'd2, ok);
    build_expected(2'd0, 4'd2, 1'b0);
    capture(exp_n, 1'b0);
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++;
      if (obs_valid[i] !== exp_valid[i] || obs_data[i] !== exp_data[i] || obs_done[i] !== exp_done[i]) begin
        n_bad++;
        $display("FAIL midrst_stream[%0d]: got v=%b d=%h done=%b, want v=%b d=%h done=%b",
                 i, obs_valid[i], obs_data[i], obs_done[i], exp_valid[i], exp_data[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int k;
    int room;
    int nb;
    int maxl;
    logic [1:0] d;
    logic [3:0] l;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      room = DEPTH - model_q.size();
      k = $urandom_range(6, 0);
      if (k > room) k = room;
      if (model_q.size() == 0 && k == 0) k = 1;
      for (int j = 0; j < k; j++) push_byte(8'($urandom));
      n_cmp++;
      if (bus.fifo_count !== 5'(model_q.size())) begin
        n_bad++;
        $display("FAIL rnd_level[%0d]: got %0d, want %0d", it, bus.fifo_count, model_q.size());
      end
      if ($urandom_range(5, 0) == 0) begin
        if ($urandom_range(1, 0) == 0) begin
          d = 2'd3;
          l = 4'($urandom_range(15, 0));
        end else begin
          d = 2'($urandom_range(3, 0));
          l = 4'd0;
        end
        send_cmd(d, l, ok);
        n_cmp++;
        if (bus.cmd_err !== 1'b1 || bus.pkt_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_err[%0d]: got err=%b v=%b, want 1/0", it, bus.cmd_err, bus.pkt_valid);
        end
        tick();
        n_cmp++;
        if (bus.fifo_count !== 5'(model_q.size()) || bus.pkt_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_err_keep[%0d]: got count=%0d v=%b, want %0d/0",
                   it, bus.fifo_count, bus.pkt_valid, model_q.size());
        end
      end else begin
        d    = 2'($urandom_range(2, 0));
        maxl = (model_q.size() > 15) ? 15 : model_q.size();
        l    = 4'($urandom_range(maxl, 1));
        nb   = $urandom_range(3, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_dest  = d;
        bus.cmd_len   = l;
        bus.busy_i    = (nb != 0);
        #1;
        for (int c = 0; c < nb; c++) begin
          n_cmp++;
          if (bus.cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_busy[%0d]: got cmd_ready=%b, want 0", it, bus.cmd_ready);
          end
          tick();
        end
        bus.busy_i = 1'b0;
        send_cmd(d, l, ok);
        build_expected(d, l, 1'b0);
        capture(exp_n, 1'b1);
        for (int i = 0; i < exp_n; i++) begin
          n_cmp++;
          if (obs_valid[i] !== exp_valid[i] || obs_data[i] !== exp_data[i] || obs_done[i] !== exp_done[i]) begin
            n_bad++;
            $display("FAIL rnd_stream[%0d][%0d]: got v=%b d=%h done=%b, want v=%b d=%h done=%b",
                     it, i, obs_valid[i], obs_data[i], obs_done[i], exp_valid[i], exp_data[i], exp_done[i]);
          end
        end
      end
    end
  endtask

`ifdef ROUTER_TX_ERR_INJECT_EN
  task automatic test_inject();
    bit ok;
    apply_reset();
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    bus.inject_err = 1'b1;
    send_cmd(2'd1, 4'd3, ok);
    bus.inject_err = 1'b0;
    build_expected(2'd1, 4'd3, 1'b1);
    capture(exp_n, 1'b0);
    n_cmp++;
    if (obs_data[4] !== 8'hAC) begin
      n_bad++;
      $display("FAIL inject_parity: got %h, want AC", obs_data[4]);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++;
      if (obs_valid[i] !== exp_valid[i] || obs_data[i] !== exp_data[i] || obs_done[i] !== exp_done[i]) begin
        n_bad++;
        $display("FAIL inject_stream[%0d]: got v=%b d=%h, want v=%b d=%h",
                 i, obs_valid[i], obs_data[i], exp_valid[i], exp_data[i]);
      end
    end
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    send_cmd(2'd1, 4'd3, ok);
    build_expected(2'd1, 4'd3, 1'b0);
    capture(exp_n, 1'b0);
    n_cmp++;
    if (obs_data[4] !== 8'hAD) begin
      n_bad++;
      $display("FAIL inject_clean: got %h, want AD", obs_data[4]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_level_wait();
    test_back_to_back();
    test_errors_busy();
    test_reset_mid_packet();
    test_random();
`ifdef ROUTER_TX_ERR_INJECT_EN
    test_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
